tx_sched: RTL and testbench
===========================

# tx_sched

Round-robin scheduler that shares the single UART `transmitter` among `NREQ` byte-stream requesters. Grants one requester for a whole packet (until `last`), optionally prefixes an ID header byte, and drives the transmitter's `write`/`D` inputs against its `full` back-pressure. Sits directly in front of `transmitter` in the same `sclk` domain.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `HDR_EN`, 1: 1 = send header byte before each packet; 0 = no header.
- `MAX_LEN`, 64: max data bytes per grant, 1..255; grant is force-ended at this count.
- `IDW`, $clog2(NREQ): width of `grant_id`.

- `sclk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8*NREQ  packed request bytes.
- `req_last`  in  NREQ  byte of requester i is the final byte of its packet.
- `req_ready`  out  NREQ  byte of requester i is consumed this cycle.
- `tx_full`  in  1  transmitter `full`; no write accepted while high.
- `tx_write`  out  1  to transmitter `write`.
- `tx_data`  out  8  to transmitter `D`.
- `grant_id`  out  IDW  currently/last granted requester.
- `busy`  out  1  high in HDR or DATA.
- `ovf`  out  1  one-cycle pulse when a grant is force-ended at `MAX_LEN`.

## Operation
- States: IDLE, HDR, DATA (enum in package).
- IDLE: combinational round-robin pick among `req_valid`, search starts at `rr_ptr`, wraps modulo NREQ. If any valid: register `grant_id`=pick, `rr_ptr`=(pick+1) mod NREQ, `cnt`=0, go HDR (HDR_EN=1) or DATA (HDR_EN=0). No valid: stay.
- HDR: `tx_data`={4'hA, grant_id zero-extended to 4 bits}; `tx_write`=!tx_full. On write go DATA. `req_ready` all 0.
- DATA: `req_ready[grant_id]`=!tx_full; other bits 0. `tx_write`=req_valid[grant_id] & !tx_full; `tx_data`=granted byte. Each transfer increments `cnt` (8-bit). Transfer with `req_last`=1 -> IDLE. Transfer with cnt+1==MAX_LEN and `req_last`=0 -> IDLE, `ovf` pulses next cycle; remaining bytes compete again as a new packet (new header).
- Granted requester dropping `req_valid` mid-packet: grant held, `tx_write`=0, no timeout.
- Non-granted valids are never consumed; they wait.
- `tx_write`/`tx_data`/`req_ready` are combinational from state, registers and `tx_full`; state, `grant_id`, `rr_ptr`, `cnt`, `ovf` are registered.

## Timing
- Reset (rst=0): state IDLE, `grant_id`=0, `rr_ptr`=0, `cnt`=0, `ovf`=0; hence `tx_write`=0, `tx_data`=0, `req_ready`=0, `busy`=0.
- Reset mid-packet: immediate return to IDLE; partial packet dropped, no header resent.
- Transfer = rising edge with `tx_write`=1 (implies `tx_full`=0).
- Latency: `req_valid` rises in cycle t while IDLE -> header written at edge ending t+1 (if not full) -> first data byte at t+2. HDR_EN=0: first data byte at t+1.
- Back-to-back: one byte per cycle while `tx_full`=0. After packet end, one IDLE cycle before next grant.
- `tx_full` rising same cycle as `req_last`: no transfer, state held.
- `tx_data` when `tx_write`=0: undefined to transmitter; bench checks it only on transfers.

## Structure
- Package `tx_sched_pkg`: state enum `sched_state_t` {IDLE, HDR, DATA}, `HDR_TAG`=4'hA, byte typedef.
- Sub-module `rr_pick`: combinational, inputs `req_valid[NREQ]`, `rr_ptr`; outputs `any`, `pick`. Reused by later arbiters.

## Test plan
- Reset: hold rst=0 with valids high -> all outputs 0, no `tx_write`; release -> requester 0 granted first (rr_ptr=0).
- Single packet: req 2 sends 8'h11,8'h22(last), tx_full=0, HDR_EN=1 -> writes 8'hA2,8'h11,8'h22 on consecutive cycles, `busy` high 3 cycles.
- Round robin: reqs 0,1,3 each hold one-byte packets -> headers in order A0,A1,A3, then A0 again if 0 re-requests.
- Back-pressure: assert `tx_full` for 5 cycles mid-packet -> no `tx_write`, `req_ready`=0, byte order preserved after release.
- MAX_LEN=4, req 1 streams 6 bytes, last on byte 6 -> A1,b1..b4, `ovf` pulse, then A1,b5,b6 (if no other requester).
- Reset mid-DATA after 2 bytes -> outputs zero at once; after release new packet gets fresh header.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types for the UART transmit scheduler.
// State encoding, header tag and byte type.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } sched_state_t;

    typedef logic [7:0] byte_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/tx_sched_if.sv
// Requester byte streams plus the transmitter write port.
// master = requesters/transmitter side, slave = scheduler.
interface tx_sched_if
    import tx_sched_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_full;
    logic              tx_write;
    byte_t             tx_data;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_full,
        input  req_ready,
        input  tx_write,
        input  tx_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_full,
        output req_ready,
        output tx_write,
        output tx_data
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid at or after
// rr_ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [IDW-1:0]  pick
);

    int             sum;
    logic [IDW-1:0] idx;

    // Walk offsets high to low so the nearest valid wins last.
    always_comb begin
        any  = 1'b0;
        pick = rr_ptr;
        sum  = 0;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (req_valid[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/tx_sched.sv
// Round-robin packet scheduler in front of the UART
// transmitter; optional ID header byte per grant.
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int HDR_EN  = 1,
    parameter int MAX_LEN = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic           sclk,
    input  logic           rst,
    tx_sched_if.slave      bus,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           ovf
);

    sched_state_t    state;
    logic [IDW-1:0]  rr_ptr;
    logic [7:0]      cnt;

    logic            any;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  nxt_ptr;

    logic            g_valid;
    logic            g_last;
    byte_t           g_data;
    logic [3:0]      gid4;
    logic            at_max;

    logic            wr;
    byte_t           data;
    logic [NREQ-1:0] ready;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .any       (any),
        .pick      (pick)
    );

    assign nxt_ptr = (pick == IDW'(NREQ - 1)) ? '0
                   : pick + 1'b1;

    assign g_valid = bus.req_valid[grant_id];
    assign g_last  = bus.req_last[grant_id];
    assign g_data  = bus.req_data[{grant_id, 3'b000} +: 8];
    assign gid4    = 4'(grant_id);
    assign at_max  = ({1'b0, cnt} + 9'd1) == 9'(MAX_LEN);

    assign busy = (state != IDLE);

    always_comb begin
        wr    = 1'b0;
        data  = '0;
        ready = '0;
        unique case (state)
            HDR: begin
                wr   = !bus.tx_full;
                data = {HDR_TAG, gid4};
            end
            DATA: begin
                ready[grant_id] = !bus.tx_full;
                wr   = g_valid & !bus.tx_full;
                data = g_data;
            end
            default: ;
        endcase
    end

    assign bus.tx_write  = wr;
    assign bus.tx_data   = data;
    assign bus.req_ready = ready;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant_id <= pick;
                        rr_ptr   <= nxt_ptr;
                        cnt      <= '0;
                        state    <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (wr) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wr) begin
                        cnt <= cnt + 8'd1;
                        if (g_last) begin
                            state <= IDLE;
                        end else if (at_max) begin
                            // Rest of the packet re-arbitrates.
                            state <= IDLE;
                            ovf   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// Scoreboard bench for tx_sched: per-requester byte queues,
// transaction-level round-robin model, decoupled monitor.
module tb_tx_sched;

    localparam int NREQ    = 4;
    localparam int MAX_LEN = 4;

    logic       sclk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    logic       ovf;

    always #5 sclk = ~sclk;

    tx_sched_if #(.NREQ(NREQ)) bus ();

    tx_sched #(
        .NREQ    (NREQ),
        .HDR_EN  (1),
        .MAX_LEN (MAX_LEN),
        .IDW     (2)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .ovf      (ovf)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] qd[NREQ][$];
    bit         ql[NREQ][$];
    logic [7:0] md[NREQ][$];
    bit         ml[NREQ][$];
    int         mptr    = 0;
    int         ovf_exp = 0;

    logic [7:0] sb_d[$];
    int         sb_id[$];

    logic [NREQ-1:0] cons = '0;
    int full_mode = 0;
    int full_lo   = 0;
    int full_hi   = 0;
    int drop_r    = -1;
    int drop_lo   = 0;
    int drop_hi   = 0;
    int cyc       = 0;
    int busy_cnt  = 0;
    int xfer      = 0;
    int ovf_seen  = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] b,
                            input bit l, input bit to_model);
        qd[r].push_back(b);
        ql[r].push_back(l);
        if (to_model) begin
            md[r].push_back(b);
            ml[r].push_back(l);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            add_byte(r, 8'($urandom), k == len - 1, 1'b1);
        end
    endtask

    // Packet-level round robin over pending requester queues.
    task automatic model_run();
        int id;
        int n;
        bit done;
        logic [7:0] b;
        bit l;
        forever begin
            id = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (mptr + k) % NREQ;
                if (id < 0 && md[j].size() > 0) id = j;
            end
            if (id < 0) break;
            sb_d.push_back({4'hA, 4'(id)});
            sb_id.push_back(id);
            n = 0;
            done = 0;
            while (!done) begin
                b = md[id].pop_front();
                l = ml[id].pop_front();
                sb_d.push_back(b);
                sb_id.push_back(id);
                n++;
                if (l) begin
                    done = 1;
                end else if (n == MAX_LEN) begin
                    ovf_exp++;
                    done = 1;
                end else if (md[id].size() == 0) begin
                    done = 1;
                end
            end
            mptr = (id + 1) % NREQ;
        end
    endtask

    task automatic step();
        bit v;
        @(negedge sclk);
        for (int i = 0; i < NREQ; i++) begin
            if (cons[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        cyc++;
        if (full_mode == 1)
            bus.tx_full = ($urandom_range(0, 99) < 30);
        else if (full_mode == 2)
            bus.tx_full = (cyc >= full_lo && cyc < full_hi);
        else
            bus.tx_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v = qd[i].size() != 0;
            if (i == drop_r && cyc >= drop_lo && cyc < drop_hi)
                v = 0;
            bus.req_valid[i] = v;
            if (v) begin
                bus.req_data[8*i +: 8] = qd[i][0];
                bus.req_last[i] = ql[i][0];
            end else begin
                bus.req_data[8*i +: 8] = 8'($urandom);
                bus.req_last[i] = 1'b0;
            end
        end
        #2;
        cons = bus.req_valid & bus.req_ready;
        if (full_mode == 2 && bus.tx_full) begin
            check("bp_write", 32'(bus.tx_write), 0);
            check("bp_ready", 32'(bus.req_ready), 0);
        end
        if (busy) busy_cnt++;
    endtask

    function automatic bit idle_all();
        bit e;
        e = (cons == '0) && (sb_d.size() == 0) && !busy;
        for (int i = 0; i < NREQ; i++)
            if (qd[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic drain(input string name, input int bound);
        bit ok;
        ok = 0;
        for (int c = 0; c < bound && !ok; c++) begin
            step();
            #2;
            if (idle_all()) ok = 1;
        end
        check({name, "_drained"}, 32'(ok), 1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        cons = '0;
        for (int i = 0; i < NREQ; i++) begin
            qd[i].delete();
            ql[i].delete();
            md[i].delete();
            ml[i].delete();
        end
        sb_d.delete();
        sb_id.delete();
        mptr = 0;
        full_mode = 0;
        drop_r = -1;
        repeat (n) step();
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin : monitor
        logic [7:0] ed;
        int eid;
        forever begin
            @(negedge sclk);
            #3;
            if (rst === 1'b1 && bus.tx_write === 1'b1) begin
                xfer++;
                if (sb_d.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got %0h expected none",
                             bus.tx_data);
                end else begin
                    ed  = sb_d.pop_front();
                    eid = sb_id.pop_front();
                    check("tx_data", 32'(bus.tx_data), 32'(ed));
                    check("grant_id", 32'(grant_id), 32'(eid));
                end
            end
            if (rst === 1'b1 && ovf === 1'b1) ovf_seen++;
        end
    end

    initial begin : stim
        int o0;
        int x0;
        bit hit;
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;

        // Reset with every requester valid.
        for (int r = 0; r < NREQ; r++)
            repeat ($urandom_range(1, 3))
                add_pkt(r, $urandom_range(1, 7));
        repeat (3) step();
        check("rst_write", 32'(bus.tx_write), 0);
        check("rst_data", 32'(bus.tx_data), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_ovf", 32'(ovf), 0);
        model_run();
        rst = 1'b1;
        full_mode = 1;
        drain("random0", 3000);

        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NREQ; r++)
                if ($urandom_range(0, 2) != 0)
                    repeat ($urandom_range(1, 2))
                        add_pkt(r, $urandom_range(1, 9));
            model_run();
            full_mode = 1;
            drain("random", 3000);
        end

        // Single two-byte packet from requester 2.
        do_reset(2);
        add_byte(2, 8'h11, 1'b0, 1'b1);
        add_byte(2, 8'h22, 1'b1, 1'b1);
        model_run();
        busy_cnt = 0;
        drain("single", 50);
        check("single_busy", 32'(busy_cnt), 3);

        // Round robin over 0,1,3, then 0 again.
        do_reset(2);
        add_byte(0, 8'h30, 1'b1, 1'b1);
        add_byte(1, 8'h31, 1'b1, 1'b1);
        add_byte(3, 8'h33, 1'b1, 1'b1);
        model_run();
        drain("rr", 100);
        add_byte(0, 8'h40, 1'b1, 1'b1);
        model_run();
        drain("rr_again", 50);

        // Back-pressure, valid gap and MAX_LEN split.
        do_reset(2);
        add_pkt(1, 6);
        model_run();
        full_mode = 2;
        full_lo = 4;
        full_hi = 9;
        drop_r = 1;
        drop_lo = 14;
        drop_hi = 17;
        o0 = ovf_seen;
        drain("bp_ovf", 100);
        check("ovf_pulse", 32'(ovf_seen - o0), 1);

        // Reset in the middle of a data phase.
        do_reset(2);
        for (int k = 0; k < 4; k++)
            add_byte(2, 8'hC1 + 8'(k), k == 3, 1'b0);
        sb_d.push_back(8'hA2); sb_id.push_back(2);
        sb_d.push_back(8'hC1); sb_id.push_back(2);
        sb_d.push_back(8'hC2); sb_id.push_back(2);
        x0 = xfer;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            step();
            #2;
            if (xfer - x0 >= 3) hit = 1;
        end
        check("mid_reach", 32'(hit), 1);
        @(posedge sclk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_write", 32'(bus.tx_write), 0);
        check("mid_ready", 32'(bus.req_ready), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_gid", 32'(grant_id), 0);
        check("mid_sb", 32'(sb_d.size()), 0);
        do_reset(2);
        add_byte(2, 8'hD1, 1'b1, 1'b1);
        model_run();
        drain("after_rst", 50);

        check("ovf_total", 32'(ovf_seen), 32'(ovf_exp));
        check("sb_empty", 32'(sb_d.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
